// File: rtl/device_uart_io.sv
// Device-bus UART peripheral: buffered 8N1 transmitter, status, cycle counter and core-id readback.
// Optional 32-bit cycle counter enabled by defining DEVICE_UART_IO_CYCLE_COUNTER_EN.
module device_uart_io #(
  parameter int unsigned NUM_CORES    = 16,
  parameter int unsigned BAUD_DIVISOR = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   device_addr,
  input  logic                         device_write_en,
  input  logic                         device_read_en,
  input  logic [15:0]                  device_data_out,
  input  logic [$clog2(NUM_CORES)-1:0] device_core_id,
  output logic [15:0]                  device_data_in,
  output logic                         uart_tx
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [15:0] BaudLast = 16'(BAUD_DIVISOR - 1);

  localparam logic [9:0] AddrTxData  = 10'h000;
  localparam logic [9:0] AddrStatus  = 10'h001;
  localparam logic [9:0] AddrCycle   = 10'h002;
  localparam logic [9:0] AddrCoreId  = 10'h003;
  localparam logic [9:0] AddrCycleHi = 10'h004;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;

  // Serializer state
  state_e      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  logic [15:0] data_in_q;
  logic [15:0] rdata;
  logic [15:0] cycle_lo;
  logic [15:0] cycle_hi;

  logic fifo_full;
  logic fifo_empty;
  logic tx_busy;
  logic wr_tx;
  logic wr_status;
  logic pop;
  logic push;
  logic overflow_set;
  logic unused_data;

  assign unused_data = ^device_data_out[15:8];

  always_comb begin
    fifo_full    = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty   = (count_q == '0);
    tx_busy      = (state_q != StIdle);
    wr_tx        = device_write_en && (device_addr == AddrTxData);
    wr_status    = device_write_en && (device_addr == AddrStatus);
    pop          = (state_q == StIdle) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push         = wr_tx && (!fifo_full || pop);
    overflow_set = wr_tx && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= device_data_out[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end else if (wr_status) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Serializer; uart_tx is registered alongside the state so it changes on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            baud_q  <= BaudLast;
            state_q <= StStart;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            baud_q  <= BaudLast;
            bit_q   <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StData: begin
          if (baud_q == '0) begin
            baud_q <= BaudLast;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (baud_q == '0) begin
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef DEVICE_UART_IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;
  logic [15:0] cycle_hi_q;

  // Upper half is snapshotted on a low-half read so software sees a coherent 32-bit pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q    <= '0;
      cycle_hi_q <= '0;
    end else begin
      if (device_write_en && (device_addr == AddrCycle)) begin
        cycle_q <= '0;
      end else begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (device_read_en && (device_addr == AddrCycle)) begin
        cycle_hi_q <= cycle_q[31:16];
      end
    end
  end

  assign cycle_lo = cycle_q[15:0];
  assign cycle_hi = cycle_hi_q;
`else
  assign cycle_lo = '0;
  assign cycle_hi = '0;
`endif

  always_comb begin
    rdata = '0;
    case (device_addr)
      AddrStatus:  rdata = {12'd0, overflow_q, tx_busy, fifo_empty, fifo_full};
      AddrCycle:   rdata = cycle_lo;
      AddrCoreId:  rdata = 16'(device_core_id);
      AddrCycleHi: rdata = cycle_hi;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_in_q <= '0;
    end else if (device_read_en) begin
      data_in_q <= rdata;
    end
  end

  assign device_data_in = data_in_q;
  assign uart_tx        = tx_q;

endmodule

// File: tb/tb_device_uart_io.sv
// Self-checking bench for device_uart_io: register vectors, directed corner cases and random
// traffic compared against a frame-timing reference model.
module tb_device_uart_io;

  localparam int unsigned B  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned NC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  addr;
  logic        we;
  logic        re;
  logic [15:0] wdata;
  logic [3:0]  cid;
  logic [15:0] data_in;
  logic        tx;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  device_uart_io #(
    .NUM_CORES   (NC),
    .BAUD_DIVISOR(B),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .device_addr    (addr),
    .device_write_en(we),
    .device_read_en (re),
    .device_data_out(wdata),
    .device_core_id (cid),
    .device_data_in (data_in),
    .uart_tx        (tx)
  );

  // Reference model: byte queue plus the start cycle of the frame on the wire.
  int unsigned cyc = 0;
  logic [7:0]  m_q [$];
  bit          m_active = 0;
  int unsigned m_fs = 0;
  logic [7:0]  m_byte = 8'h00;
  bit          m_ovf = 0;
  logic [15:0] m_rd = 16'h0;
  logic [31:0] m_cnt = 32'h0;
  logic [15:0] m_hi = 16'h0;

  function automatic bit m_busy(input int unsigned m);
    return m_active && (m >= m_fs) && (m < m_fs + 10 * B);
  endfunction

  function automatic logic m_tx(input int unsigned m);
    int unsigned k;
    if (!m_busy(m)) return 1'b1;
    k = (m - m_fs) / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_step();
    int unsigned pre;
    bit          pop;
    pre = cyc;
    cyc++;
    if (!reset) begin
      m_q.delete();
      m_active = 0;
      m_ovf    = 0;
      m_rd     = 16'h0;
      m_cnt    = 32'h0;
      m_hi     = 16'h0;
      return;
    end
    if (re) begin
      case (addr)
        10'h001: m_rd = {12'd0, m_ovf, m_busy(pre), m_q.size() == 0, m_q.size() == D};
        10'h003: m_rd = {12'd0, cid};
`ifdef DEVICE_UART_IO_CYCLE_COUNTER_EN
        10'h002: m_rd = m_cnt[15:0];
        10'h004: m_rd = m_hi;
`endif
        default: m_rd = 16'h0;
      endcase
    end
`ifdef DEVICE_UART_IO_CYCLE_COUNTER_EN
    if (re && addr == 10'h002) m_hi = m_cnt[31:16];
    m_cnt = (we && addr == 10'h002) ? 32'h0 : m_cnt + 32'd1;
`endif
    pop = !m_busy(pre) && (m_q.size() > 0);
    if (pop) begin
      m_byte   = m_q.pop_front();
      m_fs     = cyc;
      m_active = 1;
    end
    if (we && addr == 10'h000) begin
      if (m_q.size() < D) m_q.push_back(wdata[7:0]);
      else m_ovf = 1;
    end else if (we && addr == 10'h001) begin
      m_ovf = 0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [9:0] a, input logic w, input logic r, input logic [15:0] d,
                      input logic [3:0] c);
    addr  = a;
    we    = w;
    re    = r;
    wdata = d;
    cid   = c;
    @(posedge clk);
    model_step();
    #1;
    check("uart_tx", {15'd0, tx}, {15'd0, m_tx(cyc)});
    check("data_in", data_in, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'h000, 1'b0, 1'b0, 16'h0, 4'd0);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic        we;
    logic        re;
    logic [15:0] wdata;
    logic [3:0]  cid;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0]  frame;
    logic [15:0] exp_cycle;
    bit          drained;
    int          r;

    vecs[0]  = '{10'h001, 1'b0, 1'b1, 16'h0000, 4'd0,  16'h0002};
    vecs[1]  = '{10'h000, 1'b0, 1'b1, 16'h0000, 4'd0,  16'h0000};
    vecs[2]  = '{10'h003, 1'b0, 1'b1, 16'h0000, 4'd11, 16'h000B};
    vecs[3]  = '{10'h000, 1'b0, 1'b0, 16'h0000, 4'd5,  16'h000B};
    vecs[4]  = '{10'h000, 1'b0, 1'b0, 16'h0000, 4'd2,  16'h000B};
    vecs[5]  = '{10'h005, 1'b0, 1'b1, 16'h0000, 4'd7,  16'h0000};
    vecs[6]  = '{10'h3FF, 1'b0, 1'b1, 16'h0000, 4'd1,  16'h0000};
    vecs[7]  = '{10'h003, 1'b0, 1'b1, 16'h0000, 4'd15, 16'h000F};
    vecs[8]  = '{10'h001, 1'b1, 1'b0, 16'hFFFF, 4'd3,  16'h000F};
    vecs[9]  = '{10'h3FF, 1'b1, 1'b0, 16'h1234, 4'd3,  16'h000F};
    vecs[10] = '{10'h001, 1'b0, 1'b1, 16'h0000, 4'd9,  16'h0002};
    vecs[11] = '{10'h003, 1'b0, 1'b1, 16'h0000, 4'd0,  16'h0000};

    // Reset for two cycles, then register vectors from the idle state.
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wdata, vecs[i].cid);
      check($sformatf("vec%0d", i), data_in, vecs[i].exp);
    end

    // Single byte 0x41: start, LSB-first data, stop, each B cycles.
    frame = {1'b1, 8'h41, 1'b0};
    step(10'h000, 1'b1, 1'b0, 16'h0041, 4'd0);
    idle(1);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("frame_bit%0d", k), {15'd0, tx}, {15'd0, frame[k/4]});
      if (k == 20) begin
        step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
        check("status_busy", data_in, 16'h0006);
      end else begin
        idle(1);
      end
    end
    check("tx_after_frame", {15'd0, tx}, 16'h0001);
    step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
    check("status_after_frame", data_in, 16'h0002);

    // Overflow: ten back-to-back bytes, nine accepted.
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(10'h000, 1'b1, 1'b0, 16'h0030 + 16'(i), 4'd0);
    step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
    check("status_overflow", data_in, 16'h000D);
    step(10'h001, 1'b1, 1'b0, 16'h0000, 4'd0);
    step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
    check("status_ovf_cleared", data_in, 16'h0005);
    drained = 0;
    for (int i = 0; i < 9 * 41 + 20; i++) begin
      idle(1);
      if (m_q.size() == 0 && !m_busy(cyc)) begin
        drained = 1;
        break;
      end
    end
    check("drain_done", {15'd0, drained}, 16'h0001);
    step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
    check("status_drained", data_in, 16'h0002);

    // Cycle counter: zero it, read ten cycles later.
`ifdef DEVICE_UART_IO_CYCLE_COUNTER_EN
    exp_cycle = 16'd10;
`else
    exp_cycle = 16'd0;
`endif
    step(10'h002, 1'b1, 1'b0, 16'h0, 4'd0);
    idle(10);
    step(10'h002, 1'b0, 1'b1, 16'h0, 4'd0);
    check("cycle_lo", data_in, exp_cycle);
    step(10'h004, 1'b0, 1'b1, 16'h0, 4'd0);
    check("cycle_hi", data_in, 16'h0000);

    // Reset during DATA bit 3 aborts the frame and discards the FIFO.
    step(10'h000, 1'b1, 1'b0, 16'h00A5, 4'd0);
    step(10'h000, 1'b1, 1'b0, 16'h0011, 4'd0);
    step(10'h000, 1'b1, 1'b0, 16'h0022, 4'd0);
    idle(16);
    check("mid_frame_bit3", {15'd0, tx}, 16'h0000);
    reset = 1'b0;
    idle(1);
    check("tx_after_reset", {15'd0, tx}, 16'h0001);
    reset = 1'b1;
    idle(2);
    step(10'h001, 1'b0, 1'b1, 16'h0, 4'd0);
    check("status_after_abort", data_in, 16'h0002);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      reset = (r == 99) ? 1'b0 : 1'b1;
      if (r < 12)
        step(10'h000, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      else if (r < 40)
        step(10'($urandom_range(0, 5)), 1'b0, 1'b1, 16'h0, 4'($urandom));
      else if (r < 44)
        step(10'h001, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      else if (r < 46)
        step(10'h002, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      else if (r < 48)
        step(10'($urandom_range(5, 1023)), 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      else
        step(10'h000, 1'b0, 1'b0, 16'h0, 4'($urandom));
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/device_uart_io.md
Name: device_uart_io

Overview:
- Device-space peripheral on the cluster's device bus (shared addresses 0xFC00–0xFFFF; the cluster presents the low 10 bits as device_addr).
- Consumes the cluster's device_write_en, device_read_en, device_addr, device_data_out and device_core_id.
- Returns registered read data on device_data_in.
- Provides a buffered 8N1 UART transmitter, a status register, a free-running cycle counter and a requester core-id readback.

Parameters:
- NUM_CORES, 16, core count; sets device_core_id width to $clog2(NUM_CORES).
- BAUD_DIVISOR, 868, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-low.
- device_addr  input  10  device register address.
- device_write_en  input  1  write strobe, one cycle per access.
- device_read_en  input  1  read strobe, one cycle per access.
- device_data_out  input  16  write data from cluster.
- device_core_id  input  $clog2(NUM_CORES)  id of core owning current access.
- device_data_in  output  16  read data to cluster, registered.
- uart_tx  output  1  serial output, idle high.

Behaviour:
- All state is updated on posedge clk. reset low at a clock edge: FIFO empty, overflow=0, cycle counter=0, serializer IDLE, uart_tx=1, device_data_in=0.
- Register map (device_addr):
  - 0x000 TX_DATA, write-only: push device_data_out[7:0]; reads return 0.
  - 0x001 STATUS: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy (serializer not IDLE), bit3 overflow (sticky); bits 15:4 = 0. A write of any value clears overflow.
  - 0x002 CYCLE: counter bits 15:0.
  - 0x003 CORE_ID: device_core_id captured at the read strobe, zero-extended.
  - All other addresses: read 0, writes ignored.
- Read latency: exactly 1 cycle. device_data_in is loaded at the edge where device_read_en=1 and holds until the next read. The cluster samples it the cycle after the strobe.
- Write and read in the same cycle are never issued by the cluster; if they occur, the write is performed and the read returns pre-write state.
- FIFO:
  - Push on a TX_DATA write when not full.
  - A push while full drops the data and sets overflow; FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a count register of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
  - Push and pop in the same cycle are both performed, count unchanged. When full, a simultaneous pop frees the slot, so the push succeeds and overflow is not set.
- Serializer FSM:
  - IDLE: uart_tx=1. If FIFO not empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for BAUD_DIVISOR cycles, then DATA.
  - DATA: shift out 8 bits LSB first, BAUD_DIVISOR cycles each; a 3-bit bit counter, after bit 7 go to STOP.
  - STOP: uart_tx=1 for BAUD_DIVISOR cycles, then IDLE.
  - Baud counter counts BAUD_DIVISOR-1 down to 0 and reloads on each bit boundary.
  - Back-to-back frames: IDLE lasts exactly one cycle between a STOP and the next START.
- Overflow clear and overflow set in the same cycle: set wins.
- Reset asserted mid-frame: frame is aborted, uart_tx=1 on the following cycle, FIFO contents discarded.

Optional Feature:
- DEVICE_UART_IO_CYCLE_COUNTER_EN defined: 32-bit free-running counter incrementing every cycle, wrapping 0xFFFFFFFF→0.
  - CYCLE (0x002) returns bits 15:0.
  - 0x004 returns bits 31:16 as latched at the most recent CYCLE read, giving a coherent 32-bit pair.
  - Writes to 0x002 zero the counter.
- Not defined: no counter logic; 0x002 and 0x004 read 0 and writes are ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read STATUS → device_data_in=0x0002 one cycle after the strobe; uart_tx=1 throughout.
- Single byte (BAUD_DIVISOR=4): write 0x0041 to 0x000 → uart_tx low for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles. STATUS bit2=1 during the frame, 0 after.
- Overflow: with FIFO_DEPTH=8, write 10 bytes back-to-back while serializer idle → 9 accepted (1 popped to serializer), 10th dropped. STATUS reads 0x000D (full, busy, overflow); write 0 to 0x001 → STATUS 0x0005.
- Core id: read 0x003 with device_core_id=11 → device_data_in=0x000B next cycle, held while device_core_id changes.
- Cycle counter (macro on): zero via write to 0x002, read 0x002 exactly 10 cycles later → returns 10; read 0x004 → 0. Macro off: both read 0x0000.
- Reset mid-frame: assert reset during DATA bit 3 → uart_tx=1 next cycle, STATUS=0x0002 after release.
